// File: rtl/mdu_div_ctrl.sv
// mdu_div_ctrl: iterative restoring divide sequencer for DIV/DIVU in EX.
// Produces one quotient bit per cycle and holds IF/ID/EX with stall until
// the one-cycle done pulse, when remainder (hi) and quotient (lo) are valid.
// Optional build macro MDU_DIV_EARLY_OUT_EN: skips the leading-zero
// iterations of |op_a| (and BUSY entirely when op_a is zero); results are
// bit-identical to the default fixed 32-cycle build.
module mdu_div_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            cancel,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  // Iteration datapath (not reset: only meaningful after a capture).
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   dvsr;
  logic              neg_q;
  logic              neg_r;
  logic              dz;

  // Result registers presented outside the DONE cycle.
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  logic              take;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   quo_load;
  logic [XLEN:0]     shifted;
  logic [XLEN+1:0]   trial;
  logic              borrow;
  logic [XLEN-1:0]   rem_it;
  logic [XLEN-1:0]   quo_it;
  logic [XLEN-1:0]   res_lo;
  logic [XLEN-1:0]   res_hi;
  logic              unused_bits;

  // Two's-complement negate; 0x80000000 maps onto itself, which is exactly
  // the unsigned magnitude 2^31 the iteration expects.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + 1'b1;
  endfunction

  // Magnitude of a possibly signed operand.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                input logic            sgn);
    logic signed [XLEN-1:0] xs;
    xs = x;
    return (sgn && (xs < 0)) ? negate(x) : x;
  endfunction

`ifdef MDU_DIV_EARLY_OUT_EN
  logic [CNT_W:0] lz;

  // Leading-zero count; returns XLEN for an all-zero input.
  function automatic logic [CNT_W:0] clz(input logic [XLEN-1:0] x);
    logic [CNT_W:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1'b1;
        else      n = n + 1'b1;
      end
    end
    return n;
  endfunction
`endif

  // A new operation is accepted only from IDLE, and never against a flush.
  assign take  = (state == IDLE) & start & ~cancel & ~reset;
  assign mag_a = magnitude(op_a, is_signed);
  assign mag_b = magnitude(op_b, is_signed);

`ifdef MDU_DIV_EARLY_OUT_EN
  assign lz = clz(mag_a);
  // The skipped iterations would have shifted in quotient bits of 0, or of 1
  // when the divisor is zero; pre-fill them so the result is unchanged.
  assign quo_load = (mag_a << lz) |
                    ((op_b == '0) ? ~({XLEN{1'b1}} << lz) : '0);
`else
  assign quo_load = mag_a;
`endif

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  assign shifted     = {rem, quo[XLEN-1]};
  assign trial       = {1'b0, shifted} - {2'b00, dvsr};
  assign borrow      = trial[XLEN+1];
  assign rem_it      = borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_it      = {quo[XLEN-2:0], ~borrow};
  assign unused_bits = ^{trial[XLEN], shifted[XLEN]};

  // Sign fix-up of the raw unsigned result.
  assign res_lo = neg_q ? negate(quo) : quo;
  assign res_hi = neg_r ? negate(rem) : rem;

  // State and iteration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; cancel wins over every transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (take) begin
`ifdef MDU_DIV_EARLY_OUT_EN
          cnt_nxt   = lz[CNT_W-1:0];
          state_nxt = (mag_a == '0) ? DONE : BUSY;
`else
          cnt_nxt   = '0;
          state_nxt = BUSY;
`endif
        end
      end
      BUSY: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture on acceptance, then one quotient bit per BUSY cycle.
  always_ff @(posedge clk) begin
    if (take) begin
      rem   <= '0;
      quo   <= quo_load;
      dvsr  <= mag_b;
      neg_q <= is_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
      neg_r <= is_signed & op_a[XLEN-1];
      dz    <= (op_b == '0);
    end else if (state == BUSY) begin
      rem <= rem_it;
      quo <= quo_it;
    end
  end

  // Result hold registers: updated only by a completed, non-cancelled DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
  end

  assign busy        = (state == BUSY);
  assign stall       = take | busy;
  assign done        = (state == DONE) & ~cancel;
  assign lo          = done ? res_lo : lo_q;
  assign hi          = done ? res_hi : hi_q;
  assign div_by_zero = done & dz;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// tb_mdu_div_ctrl: directed self-checking bench for mdu_div_ctrl.
// Honours MDU_DIV_EARLY_OUT_EN for the expected latencies.
module tb_mdu_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cancel;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_lo;
  logic [31:0] last_hi;

  mdu_div_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .op_a        (op_a),
    .op_b        (op_b),
    .cancel      (cancel),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

`ifdef MDU_DIV_EARLY_OUT_EN
  function automatic int lead_zeros(input logic sgn, input logic [31:0] a);
    logic [31:0] m;
    int          n;
    m = (sgn && a[31]) ? (~a + 32'd1) : a;
    n = 32;
    for (int i = 0; i < 32; i++) if (m[i]) n = 31 - i;
    return n;
  endfunction
`endif

  // Full operation: start in cycle 0, expect done at the computed cycle.
  task automatic run_op(input string nm, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input logic edz);
    int   lat;
    int   cyc;
    logic seen;
    logic stall_bad;
    logic busy_bad;
`ifdef MDU_DIV_EARLY_OUT_EN
    lat = 33 - lead_zeros(sgn, a);
`else
    lat = 33;
`endif
    seen = 1'b0; stall_bad = 1'b0; busy_bad = 1'b0; cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; cyc = k; break; end
      if (stall !== 1'b1) stall_bad = 1'b1;
      if ((k > 0) && (busy !== 1'b1)) busy_bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!seen || cyc != lat) begin
      failures++;
      $display("FAIL %s latency: got cycle %0d (seen=%0b) expected %0d", nm, cyc, seen, lat);
    end
    checks++;
    if (stall_bad) begin
      failures++;
      $display("FAIL %s stall: dropped before done, expected 1", nm);
    end
    checks++;
    if (busy_bad) begin
      failures++;
      $display("FAIL %s busy: dropped before done, expected 1", nm);
    end
    checks++;
    if (lo !== elo) begin
      failures++;
      $display("FAIL %s lo: got %08h expected %08h", nm, lo, elo);
    end
    checks++;
    if (hi !== ehi) begin
      failures++;
      $display("FAIL %s hi: got %08h expected %08h", nm, hi, ehi);
    end
    checks++;
    if (div_by_zero !== edz || stall !== 1'b0) begin
      failures++;
      $display("FAIL %s done-cycle dz/stall: got %0b/%0b expected %0b/0", nm, div_by_zero, stall, edz);
    end
    @(posedge clk); #1;
    start = 1'b0; is_signed = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lo !== elo || hi !== ehi) begin
      failures++;
      $display("FAIL %s hold: done=%0b busy=%0b lo=%08h hi=%08h expected 0 0 %08h %08h",
               nm, done, busy, lo, hi, elo, ehi);
    end
    last_lo = elo; last_hi = ehi;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; cancel = 1'b0;
    op_a = '0; op_b = '0;
    #1;
    checks++;
    if ({busy, stall, done, div_by_zero} !== 4'b0000 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset: busy=%0b stall=%0b done=%0b dz=%0b hi=%08h lo=%08h expected all 0",
               busy, stall, done, div_by_zero, hi, lo);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    last_lo = '0; last_hi = '0;
  endtask

  task automatic test_unsigned;
    run_op("u100_7",   1'b0, 32'd100,       32'd7, 32'd14,        32'd2, 1'b0);
    run_op("uffff_1",  1'b0, 32'hFFFFFFFF,  32'd1, 32'hFFFFFFFF,  32'd0, 1'b0);
    run_op("u0_3",     1'b0, 32'd0,         32'd3, 32'd0,         32'd0, 1'b0);
  endtask

  task automatic test_signed;
    run_op("s-7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_op("s7_-2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0);
    run_op("s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
  endtask

  task automatic test_div_zero;
    run_op("u5_0",     1'b0, 32'd5,        32'd0, 32'hFFFFFFFF, 32'd5,        1'b1);
    run_op("s-5_0",    1'b1, 32'hFFFFFFFB, 32'd0, 32'd1,        32'hFFFFFFFB, 1'b1);
  endtask

  task automatic test_cancel_busy;
    int   cc;
    logic early_done;
`ifdef MDU_DIV_EARLY_OUT_EN
    cc = 4;
`else
    cc = 10;
`endif
    early_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
    for (int k = 0; k < cc; k++) begin
      @(posedge clk); #1;
    end
    cancel = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL cancel_busy pre: busy=%0b done=%0b expected 1 0", busy, done);
    end
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, stall, done} !== 3'b000) begin
      failures++;
      $display("FAIL cancel_busy idle: busy=%0b stall=%0b done=%0b expected 0 0 0", busy, stall, done);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) early_done = 1'b1;
    end
    checks++;
    if (early_done || lo !== last_lo || hi !== last_hi) begin
      failures++;
      $display("FAIL cancel_busy after: activity=%0b lo=%08h hi=%08h expected 0 %08h %08h",
               early_done, lo, hi, last_lo, last_hi);
    end
  endtask

  task automatic test_cancel_idle;
    logic bad;
    bad = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; is_signed = 1'b0; op_a = 32'd50; op_b = 32'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (stall !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; cancel = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL cancel_idle: start accepted under cancel, expected ignored");
    end
  endtask

  task automatic test_cancel_done;
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; op_a = 32'd5; op_b = 32'd0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    cancel = 1'b1;
    #1;
    checks++;
    if (!seen || done !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL cancel_done pulse: seen=%0b done=%0b dz=%0b expected 1 0 0", seen, done, div_by_zero);
    end
    checks++;
    if (lo !== last_lo || hi !== last_hi) begin
      failures++;
      $display("FAIL cancel_done out: lo=%08h hi=%08h expected %08h %08h", lo, hi, last_lo, last_hi);
    end
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lo !== last_lo || hi !== last_hi) begin
      failures++;
      $display("FAIL cancel_done hold: busy=%0b done=%0b lo=%08h hi=%08h expected 0 0 %08h %08h",
               busy, done, lo, hi, last_lo, last_hi);
    end
  endtask

  task automatic test_reset_mid;
    int rc;
`ifdef MDU_DIV_EARLY_OUT_EN
    rc = 3;
`else
    rc = 15;
`endif
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
    for (int k = 0; k < rc; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, stall, done, div_by_zero} !== 4'b0000 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: busy=%0b stall=%0b done=%0b dz=%0b hi=%08h lo=%08h expected all 0",
               busy, stall, done, div_by_zero, hi, lo);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    last_lo = '0; last_hi = '0;
    run_op("u20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_cancel_busy();
    run_op("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    test_cancel_idle();
    test_cancel_done();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_div_ctrl.md
Name: mdu_div_ctrl

Overview:
- Iterative 32-bit divide sequencer for the EX stage. It executes DIV/DIVU one quotient bit per cycle and holds the pipeline with a stall.
- Delivers remainder/quotient to the HI/LO write path via a one-cycle done pulse.
- Abort input kills an in-flight operation on exception/interrupt flush.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  EX holds a valid DIV/DIVU; sampled in IDLE only
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start
- op_a  in  32  dividend (rs); sampled with start
- op_b  in  32  divisor (rt); sampled with start
- cancel  in  1  flush from MEM exception/interrupt; aborts operation
- stall  out  1  hold IF/ID/EX; combinational
- busy  out  1  state == BUSY
- done  out  1  one-cycle pulse, hi/lo valid
- hi  out  32  remainder
- lo  out  32  quotient
- div_by_zero  out  1  valid with done; op_b was 0

Behaviour:
- States: IDLE, BUSY, DONE. Reset → IDLE, cnt=0, hi=0, lo=0, done=0, busy=0, div_by_zero=0. Reset takes effect asynchronously at any time, including mid-operation; no done follows.
- IDLE:
  - start & ~cancel at edge E0 → BUSY, cnt=0.
  - Latch |op_a| into quotient shift reg and |op_b| into divisor reg; remainder reg=0.
  - Latch sign flags: neg_q = is_signed & (a[31]^b[31]); neg_r = is_signed & a[31].
  - Magnitude uses two's-complement negate; 0x80000000 stays 0x80000000, treated as unsigned 2^31.
- BUSY (restoring algorithm):
  - Each edge: {rem,quo} shift left 1; trial = rem_shifted − divisor (33-bit).
  - If no borrow: rem = trial, quo[0] = 1; else quo[0] = 0.
  - cnt increments; the edge with cnt==31 performs the last iteration → DONE.
  - Exactly 32 BUSY cycles.
- DONE (one cycle):
  - done=1; lo = neg_q ? −quo : quo; hi = neg_r ? −rem : rem.
  - Next edge → IDLE.
  - hi/lo hold their values until the next DONE.
- Latency: start asserted in cycle 0; done in cycle 33.
- stall = (IDLE & start & ~cancel) | BUSY. It is low in DONE, so the EX instruction advances in the done cycle and captures hi/lo.
- cancel:
  - In BUSY or DONE: next edge → IDLE; done suppressed if cancel is asserted in DONE; hi/lo not updated.
  - In IDLE with start: start ignored.
  - cancel has priority over all transitions.
- start in BUSY/DONE is ignored. The pipeline guarantees start stays high while stalled, and it must not retrigger in DONE; the FSM takes start only from IDLE.
- Divide by zero:
  - Not trapped; runs the full 32 cycles.
  - Unsigned result: lo=0xFFFFFFFF, hi=op_a.
  - Signed: sign fix-up is applied to the same raw result (lo = neg_q ? 1 : 0xFFFFFFFF).
  - div_by_zero=1 with done.
- Overflow: 0x80000000 / 0xFFFFFFFF signed → lo=0x80000000, hi=0 (natural result, no trap).
- Reset and cancel are not required to clear hi/lo, except reset, which sets them to 0.

Optional Feature:
- MDU_DIV_EARLY_OUT_EN
- Defined:
  - In the IDLE→BUSY transition, count leading zeros of |op_a| (lz).
  - Pre-shift the quotient reg left by lz and load cnt=lz. BUSY runs 32−lz cycles.
  - op_a==0 → BUSY skipped: IDLE → DONE directly, result lo=0, hi=0, or div-by-zero values if op_b==0.
  - Results are bit-identical to the non-early-out build.
- Undefined: fixed 32-cycle latency as above.

Test Plan:
- Unsigned 100/7: start,is_signed=0,a=100,b=7 → stall high cycles 0–32, done at cycle 33, lo=14, hi=2, div_by_zero=0.
- Signed −7/2: a=0xFFFFFFF9,b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; signed 7/−2 → lo=0xFFFFFFFD, hi=1.
- Overflow: signed 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. Unsigned 0xFFFFFFFF/1 → lo=0xFFFFFFFF, hi=0.
- Divide by zero: unsigned 5/0 → done at cycle 33, lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- Cancel mid-op:
  - Start 100/7, assert cancel in cycle 10 → IDLE next edge, stall low from cycle 11, no done, hi/lo keep prior values.
  - New start 9/3 immediately after → lo=3, hi=0 after 33 cycles.
- Reset mid-op: assert reset in cycle 15 → immediately busy=0, stall=0, done=0, hi=lo=0. After release, 20/6 → lo=3, hi=2. With MDU_DIV_EARLY_OUT_EN, 20/6 completes in 6 cycles (lz=27, 5 BUSY cycles).
